// File: rtl/sha_nonce_scheduler_if.sv
// Bundles the host-side request/result signals and the engine-bank signals
// of the nonce scheduler; the scheduler connects through the slave modport.
interface sha_nonce_scheduler_if #(
    parameter int NUM_CORES = 8
);
    logic                       start;
    logic [31:0]                nonce_base;
    logic [15:0]                nonce_count;
    logic [31:0]                target;
    logic [NUM_CORES-1:0]       core_start;
    logic [32*NUM_CORES-1:0]    core_nonce;
    logic [NUM_CORES-1:0]       core_done;
    logic [32*NUM_CORES-1:0]    core_h0;
    logic                       done;
    logic                       found;
    logic [31:0]                found_nonce;
    logic [15:0]                batches_done;

    modport master (
        output start, nonce_base, nonce_count, target, core_done, core_h0,
        input  core_start, core_nonce, done, found, found_nonce, batches_done
    );

    modport slave (
        input  start, nonce_base, nonce_count, target, core_done, core_h0,
        output core_start, core_nonce, done, found, found_nonce, batches_done
    );
endinterface

// File: rtl/sha_nonce_scheduler.sv
// Splits a nonce range into batches across NUM_CORES SHA-256 engines, waits
// for the started engines to go idle and records the first nonce whose h0 beats the target.
module sha_nonce_scheduler #(
    parameter int NUM_CORES    = 8,
    parameter int STOP_ON_FIND = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    sha_nonce_scheduler_if.slave bus
);

    typedef enum logic [2:0] {IDLE, ISSUE, ARM, WAIT, EVAL, FINISH} state_t;

    state_t               state;
    logic [31:0]          next_nonce;
    logic [15:0]          remaining;
    logic [15:0]          batch_n;
    logic [NUM_CORES-1:0] active;
    logic [31:0]          target_q;
    logic [NUM_CORES-1:0] core_start_q;
    logic [31:0]          nonce_q [NUM_CORES];
    logic                 done_q;
    logic                 found_q;
    logic [31:0]          found_nonce_q;
    logic [15:0]          batches_q;

    logic [15:0]          issue_n;
    logic [NUM_CORES-1:0] issue_mask;
    logic [NUM_CORES-1:0] win;
    logic [31:0]          win_nonce;
    logic                 any_win;
    logic [15:0]          rem_after;
    logic                 found_after;

    // Downward scan leaves the lowest-index winner's nonce in win_nonce.
    always_comb begin
        issue_n    = (remaining < 16'(NUM_CORES)) ? remaining : 16'(NUM_CORES);
        issue_mask = '0;
        win        = '0;
        win_nonce  = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            issue_mask[k] = (16'(k) < issue_n);
            win[k]        = active[k] && (bus.core_h0[32*k +: 32] < target_q);
        end
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            if (win[k]) begin
                win_nonce = nonce_q[k];
            end
        end
        any_win     = |win;
        rem_after   = remaining - batch_n;
        found_after = found_q | any_win;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            next_nonce    <= '0;
            remaining     <= '0;
            batch_n       <= '0;
            active        <= '0;
            target_q      <= '0;
            core_start_q  <= '0;
            done_q        <= 1'b1;
            found_q       <= 1'b0;
            found_nonce_q <= '0;
            batches_q     <= '0;
            for (int k = 0; k < NUM_CORES; k++) begin
                nonce_q[k] <= '0;
            end
        end else begin
            core_start_q <= '0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        next_nonce    <= bus.nonce_base;
                        remaining     <= bus.nonce_count;
                        target_q      <= bus.target;
                        found_q       <= 1'b0;
                        found_nonce_q <= '0;
                        batches_q     <= '0;
                        done_q        <= 1'b0;
                        state         <= (bus.nonce_count == 16'd0) ? FINISH : ISSUE;
                    end
                end
                ISSUE: begin
                    active       <= issue_mask;
                    batch_n      <= issue_n;
                    core_start_q <= issue_mask;
                    for (int k = 0; k < NUM_CORES; k++) begin
                        nonce_q[k] <= issue_mask[k] ? (next_nonce + 32'(k)) : 32'd0;
                    end
                    state <= ARM;
                end
                // Engines need one cycle to drop core_done after the start pulse.
                ARM: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if ((bus.core_done & active) == active) begin
                        state <= EVAL;
                    end
                end
                EVAL: begin
                    if (any_win && !found_q) begin
                        found_q       <= 1'b1;
                        found_nonce_q <= win_nonce;
                    end
                    next_nonce <= next_nonce + 32'(batch_n);
                    remaining  <= rem_after;
                    batches_q  <= batches_q + 16'd1;
                    if (rem_after == 16'd0 || (STOP_ON_FIND != 0 && found_after)) begin
                        state <= FINISH;
                    end else begin
                        state <= ISSUE;
                    end
                end
                FINISH: begin
                    done_q <= 1'b1;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.core_start   = core_start_q;
    assign bus.done         = done_q;
    assign bus.found        = found_q;
    assign bus.found_nonce  = found_nonce_q;
    assign bus.batches_done = batches_q;

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_nonce_out
        assign bus.core_nonce[32*g +: 32] = nonce_q[g];
    end

endmodule

// File: tb/tb_sha_nonce_scheduler.sv
// Bench for sha_nonce_scheduler: one stop-on-find and one full-sweep instance
// driven by a simple engine model whose winning nonces are set per vector.
module tb_sha_nonce_scheduler;

    localparam int NC = 8;
    localparam logic [31:0] NONE = 32'hDEAD_BEEF;

    typedef struct {
        logic        sweep;
        logic [31:0] base;
        logic [15:0] count;
        logic [31:0] target;
        logic [31:0] win_a;
        logic [31:0] win_b;
        logic [7:0]  stale;
        logic        exp_found;
        logic [31:0] exp_nonce;
        logic [15:0] exp_batches;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    logic [31:0] win_a = NONE;
    logic [31:0] win_b = NONE;
    logic [7:0]  stale_mask = 8'h00;
    logic [7:0]  stuck_low = 8'h00;

    logic [2:0]  busy_s [NC] = '{default: 3'd0};
    logic [2:0]  busy_w [NC] = '{default: 3'd0};

    logic [7:0]   mask_log [$];
    logic [255:0] nonce_log [$];

    int n_compared = 0;
    int n_mismatched = 0;

    vec_t vecs [11];

    sha_nonce_scheduler_if #(.NUM_CORES(NC)) bus_stop ();
    sha_nonce_scheduler_if #(.NUM_CORES(NC)) bus_sweep ();

    sha_nonce_scheduler #(.NUM_CORES(NC), .STOP_ON_FIND(1)) dut_stop (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_stop.slave)
    );

    sha_nonce_scheduler #(.NUM_CORES(NC), .STOP_ON_FIND(0)) dut_sweep (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_sweep.slave)
    );

    always #5 clk = ~clk;

    // Engine model: busy for 3 cycles after a start pulse; winners report h0 = 0x10.
    always @(posedge clk) begin
        for (int k = 0; k < NC; k++) begin
            if (bus_stop.core_start[k]) busy_s[k] <= 3'd3;
            else if (busy_s[k] != 3'd0) busy_s[k] <= busy_s[k] - 3'd1;
            if (bus_sweep.core_start[k]) busy_w[k] <= 3'd3;
            else if (busy_w[k] != 3'd0) busy_w[k] <= busy_w[k] - 3'd1;
        end
    end

    for (genvar g = 0; g < NC; g++) begin : g_engine
        assign bus_stop.core_done[g] = (busy_s[g] == 3'd0) && !stuck_low[g];
        assign bus_sweep.core_done[g] = (busy_w[g] == 3'd0) && !stuck_low[g];
        assign bus_stop.core_h0[32*g +: 32] = stale_mask[g] ? 32'd0 :
            ((bus_stop.core_nonce[32*g +: 32] == win_a || bus_stop.core_nonce[32*g +: 32] == win_b)
             ? 32'h10 : 32'hFFFF_FFFF);
        assign bus_sweep.core_h0[32*g +: 32] = stale_mask[g] ? 32'd0 :
            ((bus_sweep.core_nonce[32*g +: 32] == win_a || bus_sweep.core_nonce[32*g +: 32] == win_b)
             ? 32'h10 : 32'hFFFF_FFFF);
    end

    always @(negedge clk) begin
        if (|bus_stop.core_start) begin
            mask_log.push_back(bus_stop.core_start);
            nonce_log.push_back(bus_stop.core_nonce);
        end
        if (|bus_sweep.core_start) begin
            mask_log.push_back(bus_sweep.core_start);
            nonce_log.push_back(bus_sweep.core_nonce);
        end
    end

    task automatic check_output(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic cur_done(input logic sweep);
        return sweep ? bus_sweep.done : bus_stop.done;
    endfunction

    task automatic wait_done(input logic sweep, input int budget, input string name);
        for (int c = 0; c < budget; c++) begin
            if (cur_done(sweep)) return;
            @(posedge clk); #1;
        end
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL %s: done still 0 after %0d cycles, expected 1", name, budget);
    endtask

    task automatic wait_issues(input int num, input int budget, input string name);
        for (int c = 0; c < budget; c++) begin
            if (mask_log.size() >= num) return;
            @(posedge clk); #1;
        end
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL %s: saw %0d issues after %0d cycles, expected %0d", name, mask_log.size(), budget, num);
    endtask

    task automatic drive_start(input logic sweep, input logic [31:0] base, input logic [15:0] count,
                               input logic [31:0] target);
        if (sweep) begin
            bus_sweep.nonce_base = base;
            bus_sweep.nonce_count = count;
            bus_sweep.target = target;
            bus_sweep.start = 1'b1;
        end else begin
            bus_stop.nonce_base = base;
            bus_stop.nonce_count = count;
            bus_stop.target = target;
            bus_stop.start = 1'b1;
        end
        @(posedge clk); #1;
        bus_sweep.start = 1'b0;
        bus_stop.start = 1'b0;
    endtask

    task automatic apply_stimulus(input vec_t v, input int idx);
        @(posedge clk); #1;
        mask_log.delete();
        nonce_log.delete();
        win_a = v.win_a;
        win_b = v.win_b;
        stale_mask = v.stale;
        drive_start(v.sweep, v.base, v.count, v.target);
        wait_done(v.sweep, 300, $sformatf("v%0d_done", idx));
    endtask

    // Expected lane nonces are rebuilt from the batch arithmetic: lane k of batch i gets base+8i+k.
    task automatic check_vector(input vec_t v, input int idx);
        int nb;
        int n;
        logic [7:0]   exp_mask;
        logic [255:0] exp_nonces;
        check_output($sformatf("v%0d_found", idx),
                     {255'd0, v.sweep ? bus_sweep.found : bus_stop.found}, {255'd0, v.exp_found});
        check_output($sformatf("v%0d_found_nonce", idx),
                     {224'd0, v.sweep ? bus_sweep.found_nonce : bus_stop.found_nonce}, {224'd0, v.exp_nonce});
        check_output($sformatf("v%0d_batches", idx),
                     {240'd0, v.sweep ? bus_sweep.batches_done : bus_stop.batches_done}, {240'd0, v.exp_batches});
        check_output($sformatf("v%0d_issues", idx), 256'(mask_log.size()), 256'(v.exp_batches));
        nb = (mask_log.size() < int'(v.exp_batches)) ? mask_log.size() : int'(v.exp_batches);
        for (int i = 0; i < nb; i++) begin
            n = int'(v.count) - NC * i;
            if (n > NC) n = NC;
            exp_mask = '0;
            exp_nonces = '0;
            for (int k = 0; k < NC; k++) begin
                if (k < n) begin
                    exp_mask[k] = 1'b1;
                    exp_nonces[32*k +: 32] = v.base + 32'(NC * i + k);
                end
            end
            check_output($sformatf("v%0d_b%0d_mask", idx, i), {248'd0, mask_log[i]}, {248'd0, exp_mask});
            check_output($sformatf("v%0d_b%0d_nonces", idx, i), nonce_log[i], exp_nonces);
        end
    endtask

    initial begin
        bus_stop.start = 1'b0;
        bus_stop.nonce_base = '0;
        bus_stop.nonce_count = '0;
        bus_stop.target = '0;
        bus_sweep.start = 1'b0;
        bus_sweep.nonce_base = '0;
        bus_sweep.nonce_count = '0;
        bus_sweep.target = '0;

        //               sweep base           count  target        win_a         win_b         stale  fnd fnonce        batches
        vecs[0]  = '{1'b0, 32'h0000_0100, 16'd16, 32'h0000_0000, NONE,         NONE,         8'h00, 1'b0, 32'h0,         16'd2};
        vecs[1]  = '{1'b0, 32'h0000_0100, 16'd11, 32'h0000_0000, NONE,         NONE,         8'h00, 1'b0, 32'h0,         16'd2};
        vecs[2]  = '{1'b0, 32'h0000_0200, 16'd32, 32'h0000_1000, 32'h202,      32'h205,      8'h00, 1'b1, 32'h202,       16'd1};
        vecs[3]  = '{1'b1, 32'h0000_0200, 16'd32, 32'h0000_1000, 32'h203,      32'h211,      8'h00, 1'b1, 32'h203,       16'd4};
        vecs[4]  = '{1'b0, 32'hFFFF_FFFE, 16'd4,  32'h0000_0000, NONE,         NONE,         8'h00, 1'b0, 32'h0,         16'd1};
        vecs[5]  = '{1'b0, 32'h0000_0300, 16'd3,  32'h0000_1000, NONE,         NONE,         8'hF8, 1'b0, 32'h0,         16'd1};
        vecs[6]  = '{1'b0, 32'h0000_0400, 16'd8,  32'h0000_1000, 32'h407,      NONE,         8'h00, 1'b1, 32'h407,       16'd1};
        vecs[7]  = '{1'b0, 32'h0000_0010, 16'd0,  32'h0000_1000, NONE,         NONE,         8'h00, 1'b0, 32'h0,         16'd0};
        vecs[8]  = '{1'b1, 32'h0000_0600, 16'd20, 32'h0000_1000, 32'h613,      32'h612,      8'h00, 1'b1, 32'h612,       16'd3};
        vecs[9]  = '{1'b0, 32'h0000_0700, 16'd8,  32'h0000_0010, 32'h703,      NONE,         8'h00, 1'b0, 32'h0,         16'd1};
        vecs[10] = '{1'b0, 32'h0000_0700, 16'd8,  32'h0000_0011, 32'h703,      NONE,         8'h00, 1'b1, 32'h703,       16'd1};

        repeat (3) @(posedge clk);
        #1;
        check_output("reset_done", {255'd0, bus_stop.done}, {255'd0, 1'b1});
        check_output("reset_found", {255'd0, bus_stop.found}, 256'd0);
        check_output("reset_found_nonce", {224'd0, bus_stop.found_nonce}, 256'd0);
        check_output("reset_batches", {240'd0, bus_stop.batches_done}, 256'd0);
        check_output("reset_core_start", {248'd0, bus_stop.core_start}, 256'd0);
        check_output("reset_core_nonce", bus_stop.core_nonce, 256'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) begin
            apply_stimulus(vecs[i], i);
            check_vector(vecs[i], i);
        end

        // Zero count: done drops for the single FINISH cycle and is high again two cycles after start.
        @(posedge clk); #1;
        mask_log.delete();
        nonce_log.delete();
        bus_stop.nonce_count = 16'd0;
        bus_stop.start = 1'b1;
        check_output("zc_done_at_start", {255'd0, bus_stop.done}, {255'd0, 1'b1});
        @(posedge clk); #1;
        bus_stop.start = 1'b0;
        check_output("zc_done_cycle1", {255'd0, bus_stop.done}, 256'd0);
        @(posedge clk); #1;
        check_output("zc_done_cycle2", {255'd0, bus_stop.done}, {255'd0, 1'b1});
        check_output("zc_no_core_start", 256'(mask_log.size()), 256'd0);

        // Start while busy: lane 0 held not-done keeps the search parked in WAIT.
        mask_log.delete();
        nonce_log.delete();
        win_a = 32'h500;
        win_b = NONE;
        stale_mask = 8'h00;
        stuck_low = 8'h01;
        drive_start(1'b0, 32'h500, 16'd16, 32'h1000);
        repeat (10) @(posedge clk);
        #1;
        drive_start(1'b0, 32'h900, 16'd5, 32'h1000);
        repeat (3) @(posedge clk);
        #1;
        check_output("busy_done_low", {255'd0, bus_stop.done}, 256'd0);
        check_output("busy_issues", 256'(mask_log.size()), 256'd1);
        check_output("busy_lane0_nonce", {224'd0, bus_stop.core_nonce[31:0]}, {224'd0, 32'h500});
        stuck_low = 8'h00;
        wait_done(1'b0, 100, "busy_done");
        check_output("busy_found", {255'd0, bus_stop.found}, {255'd0, 1'b1});
        check_output("busy_found_nonce", {224'd0, bus_stop.found_nonce}, {224'd0, 32'h500});
        check_output("busy_batches", {240'd0, bus_stop.batches_done}, {240'd0, 16'd1});

        // Reset during the second batch's WAIT after a winner was already recorded.
        @(posedge clk); #1;
        mask_log.delete();
        nonce_log.delete();
        win_a = 32'h501;
        drive_start(1'b1, 32'h500, 16'd16, 32'h1000);
        wait_issues(2, 100, "rst_second_issue");
        stuck_low = 8'h01;
        repeat (6) @(posedge clk);
        #1;
        check_output("rst_pre_found", {255'd0, bus_sweep.found}, {255'd0, 1'b1});
        check_output("rst_pre_done", {255'd0, bus_sweep.done}, 256'd0);
        #3;
        reset_n = 1'b0;
        #1;
        check_output("rst_done", {255'd0, bus_sweep.done}, {255'd0, 1'b1});
        check_output("rst_core_start", {248'd0, bus_sweep.core_start}, 256'd0);
        check_output("rst_found", {255'd0, bus_sweep.found}, 256'd0);
        check_output("rst_found_nonce", {224'd0, bus_sweep.found_nonce}, 256'd0);
        check_output("rst_batches", {240'd0, bus_sweep.batches_done}, 256'd0);
        check_output("rst_core_nonce", bus_sweep.core_nonce, 256'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        stuck_low = 8'h00;
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
